// File: rtl/cmdparse.sv
// cmdparse: turns a raw host byte stream into CRC-checked request strobes,
// counting corrupt and timed-out frames.
module cmdparse #(
  parameter logic [7:0]  SYNC_BYTE = 8'h7E,
  parameter logic [15:0] TIMEOUT   = 16'd20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_stb,
  output logic        req_stb,
  output logic [5:0]  req_seq,
  output logic        req_we,
  output logic [15:0] req_adr,
  output logic [7:0]  req_dat,
  output logic [7:0]  err_count,
  output logic        busy
);
  typedef enum logic [2:0] {ST_HUNT, ST_HDR, ST_ADRH, ST_ADRL, ST_DAT, ST_CRC} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_crc, w_crc;
  logic [15:0] r_idle;
  logic        r_sh_we;
  logic [5:0]  r_sh_seq;
  logic [15:0] r_sh_adr;
  logic [7:0]  r_sh_dat;
  logic        r_req_stb, r_req_we, r_busy;
  logic [5:0]  r_req_seq;
  logic [15:0] r_req_adr;
  logic [7:0]  r_req_dat, r_err;
  logic        w_good, w_bad, w_timeout;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
    return x;
  endfunction

  always_comb begin
    w_crc     = crc8(r_crc, rx_data);
    w_good    = rx_stb && r_state == ST_CRC && rx_data == r_crc;
    w_bad     = rx_stb && r_state == ST_CRC && rx_data != r_crc;
    w_timeout = !rx_stb && r_state != ST_HUNT && r_idle == TIMEOUT - 16'd1;
    w_next    = r_state;
    if (rx_stb) begin
      case (r_state)
        ST_HUNT: w_next = (rx_data == SYNC_BYTE) ? ST_HDR : ST_HUNT;
        ST_HDR:  w_next = ST_ADRH;
        ST_ADRH: w_next = ST_ADRL;
        ST_ADRL: w_next = ST_DAT;
        ST_DAT:  w_next = ST_CRC;
        default: w_next = ST_HUNT;
      endcase
    end else if (w_timeout) begin
      w_next = ST_HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_HUNT;
      r_busy    <= 1'b0;
      r_idle    <= '0;
      r_crc     <= '0;
      r_sh_we   <= 1'b0;
      r_sh_seq  <= '0;
      r_sh_adr  <= '0;
      r_sh_dat  <= '0;
      r_req_stb <= 1'b0;
      r_req_we  <= 1'b0;
      r_req_seq <= '0;
      r_req_adr <= '0;
      r_req_dat <= '0;
      r_err     <= '0;
    end else begin
      r_state   <= w_next;
      r_busy    <= w_next != ST_HUNT;
      r_idle    <= (rx_stb || r_state == ST_HUNT || w_timeout) ? 16'd0 : r_idle + 16'd1;
      r_crc     <= (r_state == ST_HUNT) ? 8'h00 : (rx_stb ? w_crc : r_crc);
      if (rx_stb && r_state == ST_HDR) {r_sh_we, r_sh_seq} <= {rx_data[7], rx_data[5:0]};
      if (rx_stb && r_state == ST_ADRH) r_sh_adr[15:8] <= rx_data;
      if (rx_stb && r_state == ST_ADRL) r_sh_adr[7:0] <= rx_data;
      if (rx_stb && r_state == ST_DAT) r_sh_dat <= rx_data;
      r_req_stb <= w_good;
      if (w_good) begin
        r_req_we  <= r_sh_we;
        r_req_seq <= r_sh_seq;
        r_req_adr <= r_sh_adr;
        r_req_dat <= r_sh_dat;
      end
      if ((w_bad || w_timeout) && r_err != 8'hFF) r_err <= r_err + 8'd1;
    end
  end

  assign req_stb   = r_req_stb;
  assign req_seq   = r_req_seq;
  assign req_we    = r_req_we;
  assign req_adr   = r_req_adr;
  assign req_dat   = r_req_dat;
  assign err_count = r_err;
  assign busy      = r_busy;
endmodule

// File: tb/tb_cmdparse.sv
// tb_cmdparse: directed frames with a scoreboard queue checked by a request monitor.
module tb_cmdparse;
  typedef struct packed {
    logic [5:0]  seq;
    logic        we;
    logic [15:0] adr;
    logic [7:0]  dat;
  } req_t;

  logic        clk, rst, rx_stb, req_stb, req_we, busy;
  logic [7:0]  rx_data, req_dat, err_count;
  logic [5:0]  req_seq;
  logic [15:0] req_adr;
  req_t        exp_q[$];
  req_t        mon_a, mon_e;
  int          n_vec, n_mis;
  logic [7:0]  exp_err;

  cmdparse #(.SYNC_BYTE(8'h7E), .TIMEOUT(16'd16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_stb(rx_stb),
    .req_stb(req_stb), .req_seq(req_seq), .req_we(req_we), .req_adr(req_adr),
    .req_dat(req_dat), .err_count(err_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] crc_model(input logic [31:0] m);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb = c[7] ^ m[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (req_stb) begin
      mon_a = '{seq: req_seq, we: req_we, adr: req_adr, dat: req_dat};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL req_unexpected: got %h expected no request at %0t", mon_a, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          n_mis++;
          $display("FAIL req_fields: got %h expected %h at %0t", mon_a, mon_e, $time);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_stb  = 1'b1;
    @(negedge clk);
    rx_stb  = 1'b0;
  endtask

  task automatic sendg(input logic [7:0] b, input int gap);
    send(b);
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] hdr, ah, al, d, input bit bad, input int gap);
    logic [7:0] c;
    c = crc_model({hdr, ah, al, d}) ^ {7'd0, bad};
    if (!bad) exp_q.push_back('{seq: hdr[5:0], we: hdr[7], adr: {ah, al}, dat: d});
    else if (exp_err != 8'hFF) exp_err++;
    sendg(8'h7E, gap);
    chk("busy_in_frame", busy, 1);
    sendg(hdr, gap);
    sendg(ah, gap);
    sendg(al, gap);
    sendg(d, gap);
    send(c);
    chk("stb_after_crc", req_stb, !bad);
    chk("busy_after_crc", busy, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_stb"}, req_stb, 0);
    chk({nm, "_req"}, {req_seq, req_we, req_adr, req_dat}, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  initial begin
    n_vec = 0; n_mis = 0; exp_err = 0;
    rst = 1'b1; rx_stb = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");
    chk("reset_err", err_count, 0);

    frame(8'h85, 8'h12, 8'h34, 8'h56, 0, 2);
    chk("good_seq", req_seq, 5);
    chk("good_adr", req_adr, 16'h1234);
    chk("good_err", err_count, 0);
    @(negedge clk);
    chk("stb_one_cycle", req_stb, 0);

    sendg(8'h7E, 2); sendg(8'h85, 2); sendg(8'h12, 2);
    rx_data = 8'h34; rx_stb = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rx_stb = 1'b0;
    chk_zero("rst_mid");
    chk("rst_mid_err", err_count, 0);

    frame(8'h85, 8'h12, 8'h34, 8'h56, 0, 2);
    frame(8'h85, 8'h12, 8'h34, 8'h56, 1, 2);
    chk("bad_keep", {req_seq, req_we, req_adr, req_dat}, {6'd5, 1'b1, 16'h1234, 8'h56});
    chk("bad_err", err_count, 1);

    sendg(8'h00, 2); sendg(8'hFF, 2);
    chk("garbage_busy", busy, 0);
    frame(8'h03, 8'h7E, 8'h00, 8'h7E, 0, 2);
    chk("embed_adr", req_adr, 16'h7E00);
    chk("embed_we", req_we, 0);

    sendg(8'h7E, 2); sendg(8'h85, 2); send(8'h12);
    repeat (15) @(negedge clk);
    chk("timeout_not_yet", busy, 1);
    @(negedge clk);
    chk("timeout_hunt", busy, 0);
    exp_err++;
    chk("timeout_err", err_count, exp_err);
    repeat (4) @(negedge clk);
    frame(8'h0A, 8'h00, 8'h01, 8'h99, 0, 2);

    exp_q.push_back('{seq: 6'd9, we: 1'b1, adr: 16'hABCD, dat: 8'hEF});
    sendg(8'h7E, 2); send(8'hC9);
    repeat (15) @(negedge clk);
    send(8'hAB);
    chk("edge_byte_busy", busy, 1);
    sendg(8'hCD, 2); sendg(8'hEF, 2);
    send(crc_model(32'hC9ABCDEF));
    chk("edge_byte_stb", req_stb, 1);
    chk("edge_byte_err", err_count, exp_err);

    frame(8'h8F, 8'h55, 8'hAA, 8'h11, 0, 0);
    frame(8'h30, 8'h0F, 8'hF0, 8'h22, 0, 0);

    for (int i = 0; i < 253; i++) frame(8'h01, 8'h02, 8'h03, 8'h04, 1, 0);
    chk("sat_reach", err_count, exp_err);
    for (int i = 0; i < 7; i++) frame(8'h01, 8'h02, 8'h03, 8'h04, 1, 0);
    chk("sat_hold", err_count, 8'hFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("sat_rst", err_count, 0);
    chk_zero("final_rst");
    chk("all_reqs_seen", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/cmdparse.md
Name: cmdparse

Overview:
- Upstream stage of the command-bus handler: converts the raw host byte stream (e.g. from a UART receiver) into validated single-cycle request strobes carrying seq, write flag, address and data.
- Hunts for a sync byte, collects a fixed 5-byte body, checks CRC-8, and emits a request only on a good frame.
- Counts corrupt and truncated frames for diagnostics.
- Sequence checking is not done here; it is the downstream consumer's job.

Parameters:
- SYNC_BYTE, 8'h7E, frame start marker; recognised only in HUNT.
- TIMEOUT, 16'd20000, max idle clocks between bytes inside a frame before abort; legal range 1..65535.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rx_data  input  8  received byte; valid when rx_stb=1
- rx_stb  input  1  one-cycle byte-valid strobe; at most one byte per cycle, no back-pressure
- req_stb  output  1  one-cycle pulse: a valid request is presented
- req_seq  output  6  request sequence number
- req_we  output  1  1=write, 0=read
- req_adr  output  16  request address
- req_dat  output  8  write data; don't-care for reads but passed through
- err_count  output  8  saturating count of CRC failures plus timeouts
- busy  output  1  1 when state != HUNT

Behaviour:
- Frame on wire: SYNC, HDR, ADRH, ADRL, DAT, CRC.
  - HDR[7]=we, HDR[6] reserved (ignored, included in CRC), HDR[5:0]=seq.
- CRC-8 algorithm:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR.
  - Covers HDR, ADRH, ADRL and DAT; excludes SYNC and CRC.
  - Update combinationally per byte: one byte per rx_stb.
- States: HUNT, HDR, ADRH, ADRL, DAT, CRC. Transitions occur only on rx_stb unless stated otherwise.
  - HUNT: byte==SYNC_BYTE -> HDR, crc<=0. Other bytes are discarded.
  - HDR/ADRH/ADRL/DAT: latch the byte into a shadow register, fold it into the crc, advance to the next state. SYNC_BYTE values are treated as ordinary data here (no stuffing).
  - CRC, byte==crc: copy shadow to req_* outputs, req_stb<=1 on the next cycle -> HUNT.
  - CRC, byte!=crc: err_count increments (saturating at 8'hFF), req_* unchanged, no req_stb -> HUNT.
- Latency: req_stb is high exactly one cycle, in the cycle after the clock edge that sampled the CRC byte's rx_stb.
- Output holding:
  - req_seq/we/adr/dat are registered and hold their last good-frame value until the next good frame.
  - They never change on a bad frame.
  - They change only in the cycle req_stb rises.
- Timeout:
  - A 16-bit idle counter clears to 0 on every rx_stb and in HUNT; otherwise it increments while state != HUNT.
  - When the counter == TIMEOUT-1 and rx_stb=0: state -> HUNT, err_count increments (saturating), counter clears, no req_stb.
  - If rx_stb=1 in the same cycle the timeout would fire, the byte wins: it is processed normally and there is no timeout that cycle.
- Back-to-back frames:
  - A SYNC byte may arrive in the cycle immediately after the CRC byte.
  - The parser is already in HUNT and must accept it; zero dead cycles between frames.
- busy = (state != HUNT), registered along with the state.
- Reset (rst=1 at a clock edge, overrides every other input including rx_stb):
  - state=HUNT, crc=0, idle counter=0.
  - req_stb=0, req_seq=0, req_we=0, req_adr=0, req_dat=0.
  - err_count=0, busy=0.
- Reset mid-frame discards the partial frame silently, with no err_count increment. A byte with rx_stb high in the reset cycle is dropped.
- err_count saturation: held at 8'hFF. It is cleared only by rst.

Test Plan:
- Good write: reset, bytes 7E,85,12,34,56,<crc by bench model> at rx_stb every 3 clks -> one req_stb one cycle after CRC strobe with req_seq=5, req_we=1, req_adr=16'h1234, req_dat=8'h56. err_count=0. busy high from the HDR byte through the CRC byte only.
- Bad CRC: same frame with CRC byte XOR 8'h01 -> no req_stb; req_* keep previous values; err_count=1; busy=0 afterwards.
- Garbage and embedded sync: bytes 00,FF,7E,03,7E,00,7E,<good crc> (seq=3, read, adr=16'h7E00, dat=8'h7E) -> leading junk ignored; the 7E bytes inside the body are taken as data; req_stb with req_adr=16'h7E00, req_dat=8'h7E, req_we=0.
- Timeout: TIMEOUT=16; send 7E,85,12 then idle 20 clks -> state back to HUNT exactly 16 clks after the last strobe; err_count=1. A following good frame is accepted normally.
- Simultaneous edge cases:
  - A byte arriving exactly on the timeout cycle is accepted.
  - Back-to-back frames with SYNC in the cycle after CRC yield two req_stb pulses 6 strobes apart.
  - rst asserted during the ADRL byte gives all outputs 0 next cycle and err_count unchanged at 0.
- Saturation: 260 consecutive bad-CRC frames -> err_count reaches 8'hFF and stays there; rst returns it to 0.
